// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, state, pc-select and ALU-control encodings
package core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITEBACK
    } state_t;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_t;

endpackage

// File: rtl/core_alu.sv
// rtl/core_alu.sv - 32-bit wrap-around ALU with zero flag
module core_alu
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_ctrl_t        control,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/core_exec.sv
// rtl/core_exec.sv - ALU operand-select muxes around the ALU
module core_exec
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    input  logic             alusrca,
    input  logic             alusrcb,
    input  alu_ctrl_t        alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;

    assign src_a = alusrca ? pc  : rs_data;
    assign src_b = alusrcb ? imm : rt_data;

    core_alu #(.WIDTH(WIDTH)) u_alu (
        .a       (src_a),
        .b       (src_b),
        .control (alu_ctrl),
        .result  (result),
        .zero    (zero)
    );

endmodule

// File: rtl/core_regfile.sv
// rtl/core_regfile.sv - 2-read/1-write register file, register 0 hard-wired to zero
module core_regfile #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REGBITS-1:0] raddr1,
    input  logic [REGBITS-1:0] raddr2,
    output logic [WIDTH-1:0]   rdata1,
    output logic [WIDTH-1:0]   rdata2,
    input  logic               we,
    input  logic [REGBITS-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata
);

    logic [WIDTH-1:0] regs [2**REGBITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REGBITS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/core.sv
// rtl/core.sv - multicycle MIPS-subset core, FETCH/DECODE/EXEC/WRITEBACK, CPI 4
module core
    import core_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] imem_data,
    input  logic [WIDTH-1:0] dmem_data,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] write_mem_data,
    output logic             write_enable
);

    state_t           state;
    pc_src_t          pc_src_e;
    logic [WIDTH-1:0] pc, ir, b_d, alu_out_e, mdr, br_target_d, j_target_d;
    logic             zero_d;

    logic [5:0]         op, funct;
    logic [REGBITS-1:0] rs, rt, rd;
    logic [WIDTH-1:0]   signext, pc_plus4, rdata1, rdata2, alu_result;
    logic               alu_zero, alusrcb, rtype_ok, reg_we;
    logic [REGBITS-1:0] reg_waddr;
    logic [WIDTH-1:0]   reg_wdata;
    alu_ctrl_t          alu_ctrl;

    assign op       = ir[31:26];
    assign funct    = ir[5:0];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign signext  = {{(WIDTH-16){ir[15]}}, ir[15:0]};
    assign pc_plus4 = pc + WIDTH'(4);

    always_comb begin
        alu_ctrl = ALU_ADD;
        alusrcb  = 1'b1;
        rtype_ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                alusrcb  = 1'b0;
                rtype_ok = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: rtype_ok = 1'b0;
                endcase
            end
            OP_BEQ: begin
                alusrcb  = 1'b0;
                alu_ctrl = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        reg_we    = 1'b0;
        reg_waddr = rt;
        reg_wdata = alu_out_e;
        if (state == S_WRITEBACK) begin
            case (op)
                OP_RTYPE: begin
                    reg_we    = rtype_ok;
                    reg_waddr = rd;
                end
                OP_ADDI: reg_we = 1'b1;
                OP_LW: begin
                    reg_we    = 1'b1;
                    reg_wdata = mdr;
                end
                default: ;
            endcase
        end
    end

    core_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_regfile (
        .clk    (clk),
        .rst_n  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (reg_we),
        .waddr  (reg_waddr),
        .wdata  (reg_wdata)
    );

    // ALU runs on the DECODE read ports so the address and compare result are
    // already registered and stable for the whole EXEC cycle.
    core_exec #(.WIDTH(WIDTH)) u_exec (
        .rs_data  (rdata1),
        .rt_data  (rdata2),
        .imm      (signext),
        .pc       (pc),
        .alusrca  (1'b0),
        .alusrcb  (alusrcb),
        .alu_ctrl (alu_ctrl),
        .result   (alu_result),
        .zero     (alu_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            pc           <= '0;
            ir           <= '0;
            b_d          <= '0;
            alu_out_e    <= '0;
            mdr          <= '0;
            br_target_d  <= '0;
            j_target_d   <= '0;
            zero_d       <= 1'b0;
            pc_src_e     <= PC_SRC_PLUS4;
            write_enable <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    ir    <= imem_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    b_d          <= rdata2;
                    alu_out_e    <= alu_result;
                    zero_d       <= alu_zero;
                    br_target_d  <= pc_plus4 + (signext << 2);
                    j_target_d   <= {pc_plus4[WIDTH-1:WIDTH-4], ir[25:0], 2'b00};
                    write_enable <= (op == OP_SW);
                    state        <= S_EXEC;
                end
                S_EXEC: begin
                    mdr          <= dmem_data;
                    write_enable <= 1'b0;
                    if (op == OP_BEQ && zero_d) pc_src_e <= PC_SRC_BRANCH;
                    else if (op == OP_J)        pc_src_e <= PC_SRC_JUMP;
                    else                        pc_src_e <= PC_SRC_PLUS4;
                    state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    case (pc_src_e)
                        PC_SRC_BRANCH: pc <= br_target_d;
                        PC_SRC_JUMP:   pc <= j_target_d;
                        default:       pc <= pc_plus4;
                    endcase
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_addr      = pc;
    assign dmem_addr      = alu_out_e;
    assign write_mem_data = b_d;

endmodule

// File: tb/tb_core.sv
// tb/tb_core.sv - scoreboard bench for core with behavioural instruction/data memories
module tb_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_data, dmem_data, imem_addr, dmem_addr, write_mem_data;
    logic        write_enable;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    core dut (
        .clk            (clk),
        .reset          (reset),
        .imem_data      (imem_data),
        .dmem_data      (dmem_data),
        .imem_addr      (imem_addr),
        .dmem_addr      (dmem_addr),
        .write_mem_data (write_mem_data),
        .write_enable   (write_enable)
    );

    assign imem_data = imem[imem_addr[9:2]];
    assign dmem_data = dmem[dmem_addr[9:2]];

    always @(posedge clk) if (write_enable) dmem[dmem_addr[9:2]] <= write_mem_data;

    always @(negedge clk) begin
        if (write_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required no write", dmem_addr, write_mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (dmem_addr !== mon_e.addr || write_mem_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL store addr=%h data=%h required addr=%h data=%h",
                             dmem_addr, write_mem_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    function automatic logic [31:0] r_op(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_op(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] j_op(logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic hold_reset();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic check_pc(input string name, input logic [31:0] exp);
        checks++;
        if (imem_addr !== exp) begin
            errors++;
            $display("FAIL %s imem_addr=%h required %h", name, imem_addr, exp);
        end
    endtask

    task automatic check_drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        hold_reset();
        repeat (4) @(posedge clk);
        #1;
        checks += 4;
        if (imem_addr !== 32'h0)      begin errors++; $display("FAIL reset_imem_addr got %h required 0", imem_addr); end
        if (write_enable !== 1'b0)    begin errors++; $display("FAIL reset_we got %b required 0", write_enable); end
        if (dmem_addr !== 32'h0)      begin errors++; $display("FAIL reset_dmem_addr got %h required 0", dmem_addr); end
        if (write_mem_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h required 0", write_mem_data); end
        release_reset();
        wait_edges(3);
        check_pc("reset_pc_hold", 32'h0);
        wait_edges(1);
        check_pc("reset_pc_first", 32'h4);
    endtask

    task automatic test_alu();
        hold_reset();
        imem[0]  = i_op(6'h08, 0, 2, 16'd5);
        imem[1]  = i_op(6'h08, 0, 3, 16'd12);
        imem[2]  = r_op(3, 2, 4, 6'h22);
        imem[3]  = r_op(4, 2, 5, 6'h25);
        imem[4]  = r_op(2, 3, 6, 6'h2a);
        imem[5]  = r_op(3, 2, 8, 6'h24);
        imem[6]  = r_op(3, 2, 9, 6'h20);
        imem[7]  = i_op(6'h3f, 0, 4, 16'h1234);
        imem[8]  = r_op(3, 2, 4, 6'h27);
        imem[9]  = i_op(6'h2b, 0, 4, 16'd20);
        imem[10] = i_op(6'h2b, 0, 5, 16'd24);
        imem[11] = i_op(6'h2b, 0, 6, 16'd28);
        imem[12] = i_op(6'h2b, 0, 8, 16'd32);
        imem[13] = i_op(6'h2b, 0, 9, 16'd36);
        imem[14] = i_op(6'h08, 0, 11, 16'hFFFD);
        imem[15] = r_op(11, 2, 12, 6'h2a);
        imem[16] = i_op(6'h2b, 0, 12, 16'd40);
        imem[17] = i_op(6'h2b, 0, 11, 16'd44);
        imem[18] = i_op(6'h04, 0, 0, 16'hFFFF);
        expect_write(32'd20, 32'd7);
        expect_write(32'd24, 32'd7);
        expect_write(32'd28, 32'd1);
        expect_write(32'd32, 32'd4);
        expect_write(32'd36, 32'd17);
        expect_write(32'd40, 32'd1);
        expect_write(32'd44, 32'hFFFF_FFFD);
        release_reset();
        wait_edges(19 * 4 + 8);
        check_pc("alu_loop_pc", 32'd72);
        check_drain("alu_writes");
    endtask

    task automatic test_load_store();
        hold_reset();
        dmem[8'h10] = 32'hDEADBEEF;
        imem[0] = i_op(6'h23, 0, 7, 16'h0040);
        imem[1] = i_op(6'h2b, 0, 7, 16'h0044);
        imem[2] = i_op(6'h04, 0, 0, 16'hFFFF);
        expect_write(32'h44, 32'hDEADBEEF);
        release_reset();
        wait_edges(16);
        check_drain("ldst_writes");
        checks++;
        if (dmem[8'h11] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ldst_mem got %h required deadbeef", dmem[8'h11]);
        end
    endtask

    task automatic test_branch();
        hold_reset();
        imem[2] = i_op(6'h04, 0, 0, 16'd2);
        imem[3] = i_op(6'h08, 0, 1, 16'd1);
        imem[4] = i_op(6'h08, 0, 1, 16'd2);
        imem[5] = i_op(6'h2b, 0, 1, 16'h0080);
        imem[6] = i_op(6'h04, 0, 0, 16'hFFFF);
        expect_write(32'h80, 32'h0);
        release_reset();
        wait_edges(12);
        check_pc("beq_taken", 32'd20);
        wait_edges(12);
        check_pc("beq_taken_loop", 32'd24);
        check_drain("beq_taken_writes");

        hold_reset();
        imem[0] = i_op(6'h08, 0, 1, 16'd1);
        imem[2] = i_op(6'h04, 1, 0, 16'd2);
        imem[3] = i_op(6'h04, 0, 0, 16'hFFFF);
        release_reset();
        wait_edges(12);
        check_pc("beq_not_taken", 32'd12);
        wait_edges(4);
        check_pc("self_loop_1", 32'd12);
        wait_edges(8);
        check_pc("self_loop_3", 32'd12);
    endtask

    task automatic test_jump();
        hold_reset();
        imem[0]  = j_op(26'h00000C);
        imem[12] = j_op(26'h000010);
        imem[16] = i_op(6'h08, 0, 0, 16'd9);
        imem[17] = i_op(6'h2b, 0, 0, 16'd0);
        imem[18] = i_op(6'h04, 0, 0, 16'hFFFF);
        expect_write(32'h0, 32'h0);
        release_reset();
        wait_edges(4);
        check_pc("jump_first", 32'h30);
        wait_edges(4);
        check_pc("jump_second", 32'h40);
        wait_edges(12);
        check_pc("jump_loop", 32'h48);
        check_drain("zero_reg_store");
    endtask

    task automatic test_async_reset();
        hold_reset();
        dmem[8'h18] = 32'hA5A5A5A5;
        imem[0] = i_op(6'h08, 0, 2, 16'd3);
        imem[1] = i_op(6'h2b, 0, 2, 16'h0060);
        release_reset();
        wait_edges(6);
        checks++;
        if (write_enable !== 1'b1 || dmem_addr !== 32'h60 || write_mem_data !== 32'd3) begin
            errors++;
            $display("FAIL sw_exec we=%b addr=%h data=%h required we=1 addr=60 data=3",
                     write_enable, dmem_addr, write_mem_data);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (write_enable !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_abort we=%b pc=%h required we=0 pc=0", write_enable, imem_addr);
        end
        wait_edges(4);
        checks++;
        if (dmem[8'h18] !== 32'hA5A5A5A5 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_no_write mem=%h pc=%h required mem=a5a5a5a5 pc=0", dmem[8'h18], imem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jump();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core.md
Name: core

Overview:
- 32-bit MIPS-subset processor core with separate instruction and data memory ports. Both memory ports are expected to have asynchronous (combinational) read and synchronous write.
- Executes one instruction at a time through a fixed 4-state sequence FETCH -> DECODE -> EXEC -> WRITEBACK, giving CPI = 4.
- Top-level compute block. The memory model is external.

Parameters:
- WIDTH, 32, datapath and address width.
- REGBITS, 5, register-index width; the register file has 2^REGBITS entries.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_data  in  32  instruction word at imem_addr.
- dmem_data  in  32  data word at dmem_addr.
- imem_addr  out  32  byte address of the instruction; always equals pc.
- dmem_addr  out  32  byte address for load/store; equals the EXEC-stage ALU result register.
- write_mem_data  out  32  store data; equals the rt register value latched in DECODE.
- write_enable  out  1  store strobe; memory writes on the clk rising edge while it is high.

Behaviour:
- Reset (reset low, asynchronous):
  - pc=0; state=FETCH; write_enable=0.
  - All registers and pipeline latches = 0.
  - dmem_addr=0 and write_mem_data=0.
- FETCH: latch imem_data into the instruction register (IR).
- DECODE:
  - Read rs (IR[25:21]) and rt (IR[20:16]) into A and B (rdata1_D, rdata2_D).
  - Sign-extend IR[15:0].
  - Compute branch target = pc+4 + (signext<<2).
  - Compute jump target = {pc+4[31:28], IR[25:0], 2'b00}.
- EXEC:
  - ALU executes; result latched into ALUOut, which drives dmem_addr.
  - lw: latch dmem_data into MDR at the end of EXEC.
  - sw: write_enable is high for exactly this one cycle, with dmem_addr = A+signext and write_mem_data = B.
  - beq: taken when A==B.
  - pc_src_E is registered at the end of EXEC: 0=pc+4, 1=branch target, 2=jump target.
- WRITEBACK:
  - Register write, if any.
  - pc is updated per pc_src_E.
  - Next state is FETCH.
- Supported instructions (opcode/funct in hex):
  - R-type op 00 with funct 20 add, 22 sub, 24 and, 25 or, 2a slt (signed; result 1/0). Destination is rd = IR[15:11].
  - addi op 08: rt <= A+signext.
  - lw op 23: rt <= MDR.
  - sw op 2b.
  - beq op 04.
  - j op 02.
- Unknown opcode or funct: executes as a NOP, and pc advances by 4.
- Arithmetic is 32-bit wrap-around; overflow is ignored and no exceptions are raised.
- Register 0 reads as 0; writes to it are discarded.
- Register file: two combinational read ports, one write port written on the rising edge.
- A branch or jump target equal to pc (self-loop) is legal and repeats indefinitely.
- Reset asserted mid-instruction aborts it immediately. No memory write occurs after reset is asserted.
- write_enable is never high outside EXEC of a sw.

Decomposition:
- Shared package holds:
  - opcode and funct constants;
  - the state encoding FETCH/DECODE/EXEC/WRITEBACK;
  - the pc_src encoding;
  - the ALU control encoding (ADD, SUB, AND, OR, SLT).
- Sub-modules:
  - alu: inputs a, b, control; outputs result and zero.
  - exec: wraps the alu and the operand-select muxes (alusrca, alusrcb).
  - The register file is a small separate module.

Test Plan:
- Reset: hold reset low for 4 cycles -> imem_addr=0, write_enable=0. Release -> imem_addr is 4 after exactly 4 cycles.
- ALU sequence:
  - Stimulus: addi $2,$0,5; addi $3,$0,12; sub $4,$3,$2; or $5,$4,$2; slt $6,$2,$3; sw $4,20($0).
  - Required: a single write_enable pulse with dmem_addr=20, write_mem_data=7; $5=7 and $6=1.
- Load/store round trip:
  - Stimulus: memory word 0x40 preloaded with 0xDEADBEEF; lw $7,0x40($0) then sw $7,0x44($0).
  - Required: a write of 0xDEADBEEF to address 0x44.
- Branch:
  - Taken: beq $0,$0,+2 at pc=8 -> next imem_addr=20.
  - Not taken: with $1=1, beq $1,$0,+2 -> next imem_addr=12.
  - Negative offset: -1 -> self-loop.
- Jump: j 0x10 at pc=0x30 -> next imem_addr=0x40. $0 write: addi $0,$0,9 then sw $0,0($0) -> stores 0.
- Async reset: assert reset during EXEC of a sw -> write_enable drops immediately, no write occurs, and pc=0.
